clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
Parametrised multi-channel clock divider. It is the successor to the single-output 50 MHz to 1 Hz divider. NUM_CH independent channels each divide Clk_In by a runtime-programmable divisor, in either 50% square-wave mode or single-cycle tick mode. Divisor changes are glitch-free, and a global Sync re-aligns all channels. It feeds blink, turn-signal and debounce timing across the board design.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
SEL_W, 2, width of the channel-select field; must satisfy 2**SEL_W >= NUM_CH
CNT_W, 26, counter and divisor width
DEFAULT_DIV, 25000000, divisor loaded into every channel at reset (50 MHz to 1 Hz in toggle mode)

Ports:
Clk_In  input  1  system clock; all logic on rising edge
Div_Rst_n  input  1  asynchronous, active-low reset
Div_En  input  NUM_CH  per-channel enable
Div_Load  input  1  one-cycle strobe; writes Div_Value and Div_Mode to the channel given by Div_Ch_Sel
Div_Ch_Sel  input  SEL_W  target channel for Div_Load
Div_Value  input  CNT_W  divisor N
Div_Mode  input  1  0 = toggle (square wave), 1 = pulse (tick)
Sync  input  1  one-cycle strobe; restarts all channels in phase
Clk_Out  output  NUM_CH  divided outputs, registered
Tick_Out  output  NUM_CH  one-cycle pulse, once per output period, registered
Pend  output  NUM_CH  high while a loaded divisor is waiting to take effect

Behaviour:
- Reset (Div_Rst_n = 0, asynchronous):
  - every channel: div_reg = DEFAULT_DIV, mode = toggle, count = 0, shadow cleared
  - Clk_Out = 0, Tick_Out = 0, Pend = 0
- Per-channel counter, enabled and N >= 1:
  - count runs 0..N-1
  - terminal edge = edge on which count == N-1; on it count <= 0 and the event fires
- Toggle mode event:
  - Clk_Out inverts, giving an output period of 2N Clk_In cycles at 50% duty
  - Tick_Out = 1 for one cycle only on the event that drives Clk_Out 0 to 1
- Pulse mode event:
  - Tick_Out = 1 for one cycle; Clk_Out mirrors Tick_Out
  - Output period is N cycles
  - N = 1 gives Tick_Out continuously high
- Latency: with enable high after reset release, the first event register update occurs on the Nth rising edge.
- N = 0: channel idle. Count held at 0, Clk_Out = 0, Tick_Out = 0.
- Div_En[i] = 0 (synchronous): count <= 0, Clk_Out <= 0, Tick_Out <= 0. Re-enabling restarts from count 0, with the first event N edges later.
- Load:
  - Div_Load writes the shadow {value, mode} for channel Div_Ch_Sel and sets Pend[i].
  - Div_Ch_Sel >= NUM_CH: load ignored, no state change.
  - Channel running: shadow transfers to div_reg/mode on the next terminal edge; Pend clears on the same edge. No truncated or runt output phase occurs.
  - Channel disabled or div_reg == 0: transfer on the next edge. count <= 0, Clk_Out <= 0, Pend clears.
  - Second load before transfer: overwrites the shadow (last write wins).
- Sync:
  - On the next edge, all channels get count <= 0, Clk_Out <= 0, Tick_Out <= 0, and all pending shadows transfer immediately.
  - Load and Sync in the same cycle: the new load is included in the immediate transfer.
  - Channels with the same N are phase-aligned afterwards.
- Terminal edge coinciding with Sync: Sync wins, no event fires.
- Reset mid-operation: outputs drop to 0 asynchronously. Any pending load is discarded.
- Arithmetic: count compares against div_reg - 1 computed in CNT_W bits. The N = 0 case is handled separately so the subtraction never wraps. No combinational path exists from inputs to outputs.
- Implementation: per-channel generate loop with a 3-state control FSM {IDLE, RUN, PEND}.
  - IDLE: N = 0 or disabled
  - PEND: shadow valid, awaiting terminal edge
  - Transitions: IDLE to RUN on enable with N >= 1; RUN to PEND on load; PEND to RUN on transfer; any state to IDLE when disabled or N = 0.

Test Plan:
1. Reset, then load ch0 with N = 4, toggle mode, enabled -> Clk_Out[0] rises on edge 4, falls on edge 8, period 8 cycles; Tick_Out[0] pulses once per 8 cycles, coincident with the rise.
2. Ch1 with N = 3, pulse mode -> Tick_Out[1] = Clk_Out[1] high for one cycle at edges 3, 6, 9; with N = 1, Tick_Out[1] stays continuously high.
3. Ch0 running with N = 10; load N = 2 at count 3 -> Pend[0] = 1 until edge 10, every output phase keeps its old length of 10 cycles, then period 4 with no runt pulse.
4. Ch0 N = 4 and ch2 N = 4 started 2 cycles apart; pulse Sync -> both Clk_Out low next edge, then toggle on the same edges thereafter; load to Div_Ch_Sel = 5 with NUM_CH = 4 -> no change.
5. N = 0 load -> outputs 0, no Tick_Out. Deassert Div_En mid-period -> outputs 0 next edge; reassert -> first event 4 edges later.
6. Assert Div_Rst_n = 0 mid-high-phase with a load pending -> Clk_Out drops immediately and Pend clears; after release, div_reg = DEFAULT_DIV (check with DEFAULT_DIV = 5 override: first rise on edge 5).

Source files
------------

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable clock divider
// Each channel counts 0..N-1 and fires an event on the terminal edge; divisor loads are shadowed until that edge.
module clock_divider_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          SEL_W       = 2,
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25000000
) (
  input  logic              Clk_In,
  input  logic              Div_Rst_n,
  input  logic [NUM_CH-1:0] Div_En,
  input  logic              Div_Load,
  input  logic [SEL_W-1:0]  Div_Ch_Sel,
  input  logic [CNT_W-1:0]  Div_Value,
  input  logic              Div_Mode,
  input  logic              Sync,
  output logic [NUM_CH-1:0] Clk_Out,
  output logic [NUM_CH-1:0] Tick_Out,
  output logic [NUM_CH-1:0] Pend
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} state_t;

  function automatic state_t st_after(input logic [CNT_W-1:0] d, input logic en);
    return (d == '0 || !en) ? ST_IDLE : ST_RUN;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_div, r_cnt, r_sh_div;
    logic             r_mode, r_sh_mode, r_clk, r_tick;
    state_t           r_state;
    logic             w_hit, w_pend, w_last;

    assign w_hit  = Div_Load && (Div_Ch_Sel == SEL_W'(g));
    assign w_pend = (r_state == ST_PEND);
    // div_reg == 0 is excluded first so div_reg - 1 never wraps into a false terminal match
    assign w_last = (r_div != '0) && (r_cnt == r_div - CNT_W'(1));

    always_ff @(posedge Clk_In or negedge Div_Rst_n) begin
      if (!Div_Rst_n) begin
        r_div     <= CNT_W'(DEFAULT_DIV);
        r_mode    <= 1'b0;
        r_cnt     <= '0;
        r_sh_div  <= '0;
        r_sh_mode <= 1'b0;
        r_clk     <= 1'b0;
        r_tick    <= 1'b0;
        r_state   <= ST_IDLE;
      end else begin
        if (w_hit) begin
          r_sh_div  <= Div_Value;
          r_sh_mode <= Div_Mode;
        end
        if (Sync) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          if (w_hit) begin
            r_div  <= Div_Value;
            r_mode <= Div_Mode;
          end else if (w_pend) begin
            r_div  <= r_sh_div;
            r_mode <= r_sh_mode;
          end
          r_state <= st_after(w_hit ? Div_Value : (w_pend ? r_sh_div : r_div), Div_En[g]);
        end else if (!Div_En[g] || r_div == '0) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          if (w_pend) begin
            r_div  <= r_sh_div;
            r_mode <= r_sh_mode;
          end
          r_state <= w_hit ? ST_PEND : st_after(w_pend ? r_sh_div : r_div, Div_En[g]);
        end else begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_mode) begin
              r_clk  <= 1'b1;
              r_tick <= 1'b1;
            end else begin
              r_clk  <= ~r_clk;
              r_tick <= ~r_clk;
            end
            if (w_pend) begin
              r_div  <= r_sh_div;
              r_mode <= r_sh_mode;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
            if (r_mode) r_clk <= 1'b0;
          end
          if (w_hit || (w_pend && !w_last)) r_state <= ST_PEND;
          else if (w_pend)                  r_state <= st_after(r_sh_div, 1'b1);
          else                              r_state <= ST_RUN;
        end
      end
    end

    assign Clk_Out[g]  = r_clk;
    assign Tick_Out[g] = r_tick;
    assign Pend[g]     = w_pend;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - self-checking bench for clock_divider_multi
// Reference model tracks cycles elapsed since each channel's phase restart and fires events on multiples of N.
module tb_clock_divider_multi;
  localparam int NCH  = 4;
  localparam int SW   = 3;
  localparam int CW   = 8;
  localparam int DDIV = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           load, mode, sync;
  logic [SW-1:0]  sel;
  logic [CW-1:0]  val;
  logic [NCH-1:0] clk_o, tick_o, pend_o;

  int errors = 0;
  int checks = 0;

  int m_e[NCH], m_div[NCH], m_sdiv[NCH];
  bit m_mode[NCH], m_smode[NCH], m_pend[NCH], m_clk[NCH], m_tick[NCH];

  clock_divider_multi #(.NUM_CH(NCH), .SEL_W(SW), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .Clk_In(clk), .Div_Rst_n(rst_n), .Div_En(en), .Div_Load(load), .Div_Ch_Sel(sel),
    .Div_Value(val), .Div_Mode(mode), .Sync(sync),
    .Clk_Out(clk_o), .Tick_Out(tick_o), .Pend(pend_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_e[i] = 0; m_div[i] = DDIV; m_mode[i] = 0; m_sdiv[i] = 0; m_smode[i] = 0;
      m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      hit = load && (int'(sel) == i);
      if (sync) begin
        m_e[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        if (hit) begin m_div[i] = int'(val); m_mode[i] = mode; end
        else if (m_pend[i]) begin m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; end
        m_pend[i] = 0;
      end else if (!en[i] || m_div[i] == 0) begin
        m_e[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        if (m_pend[i]) begin m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0; end
        if (hit) m_pend[i] = 1;
      end else begin
        m_e[i]++;
        m_tick[i] = 0;
        if (m_mode[i]) m_clk[i] = 0;
        if (m_e[i] % m_div[i] == 0) begin
          if (m_mode[i]) begin m_clk[i] = 1; m_tick[i] = 1; end
          else begin m_clk[i] = !m_clk[i]; m_tick[i] = m_clk[i]; end
          if (m_pend[i]) begin
            m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0; m_e[i] = 0;
          end
        end
        if (hit) m_pend[i] = 1;
      end
      if (hit) begin m_sdiv[i] = int'(val); m_smode[i] = mode; end
    end
  endtask

  function automatic logic [3*NCH-1:0] mvec();
    logic [3*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      v[2*NCH+i] = m_clk[i]; v[NCH+i] = m_tick[i]; v[i] = m_pend[i];
    end
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic load_ch(input int ch, input int n, input bit md);
    sel = SW'(ch); val = CW'(n); mode = md; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic setup_ch(input int ch, input int n, input bit md);
    en[ch] = 1'b0;
    load_ch(ch, n, md);
    cyc();
  endtask

  task automatic quiesce();
    en = '0;
    for (int k = 0; k < 3; k++) cyc();
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if ({clk_o, tick_o, pend_o} !== '0)
      $display("FAIL reset_outputs dut=%h exp=0", {clk_o, tick_o, pend_o});
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec())
        $display("FAIL reset_model k=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
    end
  endtask

  task automatic test_toggle();
    setup_ch(0, 4, 1'b0);
    en[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic ec, et;
      cyc();
      ec = ((k / 4) % 2) == 1;
      et = (k % 8) == 4;
      checks++;
      if ({clk_o[0], tick_o[0]} !== {ec, et}) begin
        errors++;
        $display("FAIL toggle_n4 edge=%0d dut=%b exp=%b", k, {clk_o[0], tick_o[0]}, {ec, et});
      end
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL toggle_model edge=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    quiesce();
  endtask

  task automatic test_pulse();
    setup_ch(1, 3, 1'b1);
    en[1] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      logic e;
      cyc();
      e = (k % 3) == 0;
      checks++;
      if ({clk_o[1], tick_o[1]} !== {e, e}) begin
        errors++;
        $display("FAIL pulse_n3 edge=%0d dut=%b exp=%b", k, {clk_o[1], tick_o[1]}, {e, e});
      end
    end
    load_ch(1, 1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      cyc();
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL pulse_model k=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
      if (k >= 3) begin
        checks++;
        if ({clk_o[1], tick_o[1]} !== 2'b11) begin
          errors++;
          $display("FAIL pulse_n1 k=%0d dut=%b exp=11", k, {clk_o[1], tick_o[1]});
        end
      end
    end
    quiesce();
  endtask

  task automatic test_glitch_free();
    setup_ch(0, 10, 1'b0);
    en[0] = 1'b1;
    for (int k = 1; k <= 3; k++) cyc();
    sel = '0; val = 8'd2; mode = 1'b0; load = 1'b1;
    for (int k = 4; k <= 20; k++) begin
      logic ec, ep;
      cyc();
      load = 1'b0;
      ep = (k < 10);
      ec = (k < 10) ? 1'b0 : (((k - 10) / 2) % 2 == 0);
      checks++;
      if ({clk_o[0], pend_o[0]} !== {ec, ep}) begin
        errors++;
        $display("FAIL glitch_free edge=%0d dut=%b exp=%b", k, {clk_o[0], pend_o[0]}, {ec, ep});
      end
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL glitch_model edge=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    quiesce();
  endtask

  task automatic test_sync();
    setup_ch(0, 4, 1'b0);
    setup_ch(2, 4, 1'b0);
    en[0] = 1'b1;
    cyc(); cyc();
    en[2] = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    checks++;
    if ({clk_o[0], clk_o[2]} !== 2'b00) begin
      errors++;
      $display("FAIL sync_low dut=%b exp=00", {clk_o[0], clk_o[2]});
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      checks++;
      if (clk_o[0] !== clk_o[2] || {clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL sync_align k=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    load_ch(5, 1, 1'b1);
    checks++;
    if (pend_o !== 4'b0000) begin
      errors++;
      $display("FAIL bad_sel pend=%b exp=0000", pend_o);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL bad_sel_model k=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    quiesce();
  endtask

  task automatic test_idle_enable();
    setup_ch(1, 0, 1'b0);
    en[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++;
      if ({clk_o[1], tick_o[1]} !== 2'b00) begin
        errors++;
        $display("FAIL n0_idle k=%0d dut=%b exp=00", k, {clk_o[1], tick_o[1]});
      end
    end
    en[0] = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    en[0] = 1'b0;
    cyc();
    checks++;
    if ({clk_o[0], tick_o[0]} !== 2'b00) begin
      errors++;
      $display("FAIL disable dut=%b exp=00", {clk_o[0], tick_o[0]});
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++;
      if (clk_o[0] !== (k >= 4) || {clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL reenable edge=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    quiesce();
  endtask

  task automatic test_reset_mid();
    int n;
    en[0] = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (clk_o[0] !== 1'b1 && n < 20);
    checks++;
    if (clk_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_timeout clk=%b exp=1", clk_o[0]);
    end
    load_ch(0, 7, 1'b0);
    checks++;
    if ({clk_o[0], pend_o[0]} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre dut=%b exp=11", {clk_o[0], pend_o[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({clk_o, tick_o, pend_o} !== '0) begin
      errors++;
      $display("FAIL reset_async dut=%h exp=0", {clk_o, tick_o, pend_o});
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++;
      if ({clk_o[0], tick_o[0]} !== {k >= 5, k == 5}) begin
        errors++;
        $display("FAIL reset_default edge=%0d dut=%b exp=%b", k, {clk_o[0], tick_o[0]}, {k >= 5, k == 5});
      end
    end
    quiesce();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
      load = ($urandom_range(0, 4) == 0);
      sel  = SW'($urandom_range(0, 5));
      val  = CW'($urandom_range(0, 6));
      mode = 1'($urandom_range(0, 1));
      sync = ($urandom_range(0, 29) == 0);
      cyc();
      checks++;
      if ({clk_o, tick_o, pend_o} !== mvec()) begin
        errors++;
        $display("FAIL random k=%0d dut=%h exp=%h", k, {clk_o, tick_o, pend_o}, mvec());
      end
    end
    load = 1'b0; sync = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; load = 1'b0; mode = 1'b0; sync = 1'b0; sel = '0; val = '0;
    model_reset();
    test_reset();
    test_toggle();
    test_pulse();
    test_glitch_free();
    test_sync();
    test_idle_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
